iter_mult_ctrl: RTL
===================

Name: iter_mult_ctrl

Overview:
- Sequencer and datapath for a multi-cycle, shift-add integer multiplier that backs the MUL instruction in the CPU execute stage.
- Holds operands, partial product and step counter in synchronous registers.
- Steps one bit per clock and presents the low WIDTH bits of the product through valid/ready handshakes on both sides.
- The pipeline controller uses busy to stall and flush to cancel an in-flight operation.

Parameters:
- WIDTH, 64, operand and result width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH)+1, step-counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- flush  input  1  synchronous cancel of any in-flight or completed-but-unread operation.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  consumer takes the product this cycle.
- product  output  WIDTH  low WIDTH bits of a*b; identical for signed and unsigned operands.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state=IDLE; product, internal multiplicand, multiplier and accumulator registers = 0; count = 0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, product=0.
  - Reset asserted mid-RUN or in DONE aborts the operation identically; reset has priority over flush and over all handshakes.
- States: IDLE, RUN, DONE. Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- IDLE:
  - in_ready=1.
  - When in_valid=1 and flush=0 at an edge: mcand<=a, mplier<=b, acc<=0, count<=0, state<=RUN.
  - When in_valid=0, or flush=1, remain in IDLE.
- RUN, per edge:
  - If mplier[0]=1 then acc<=acc+mcand, else acc holds. The adder is WIDTH bits and carry-out is discarded.
  - mcand<=mcand<<1 with zero fill; mplier<=mplier>>1 with logical zero fill; count<=count+1.
  - When count==WIDTH-1 at the edge (the WIDTH-th step): the final acc value is also loaded into product and state<=DONE.
  - in_ready=0; in_valid and operand changes are ignored.
- DONE:
  - out_valid=1; product is held stable until the handshake completes.
  - out_valid=1 and out_ready=1 at an edge: state<=IDLE, so in_ready=1 the following cycle.
  - A new operand cannot be accepted in the same cycle as the product is drained.
- Latency: if accepted at edge E0, out_valid=1 starting in the cycle after edge E0+WIDTH, exactly WIDTH cycles after the accept edge. The step count is fixed; there is no early termination for zero or small operands.
- flush=1 at an edge in RUN or DONE: state<=IDLE, count<=0, and out_valid drops the next cycle. product keeps its last registered value, but it is not valid. In IDLE, flush only suppresses acceptance.
- Simultaneous out_ready=1 and flush=1 in DONE: go to IDLE. The transfer counts as cancelled and the consumer must ignore it.
- Wrap-around: only the low WIDTH bits are kept. There is no overflow flag.

Test Plan:
- Reset, then check idle outputs: hold reset for 2 edges, release -> in_ready=1, busy=0, out_valid=0, product=0.
- Basic product and exact latency: WIDTH=64, a=3, b=5, in_valid pulsed for one cycle with out_ready=1 -> busy=1 next cycle; out_valid=1 exactly 64 cycles after the accept edge with product=15; in_ready=1 on the cycle after the drain.
- Wrap-around and signed operands:
  - a=b=64'hFFFF_FFFF_FFFF_FFFF -> product=1.
  - a=-7 (two's complement), b=6 -> product=-42 (64'hFFFF_FFFF_FFFF_FFD6).
  - a=0, b=any -> product=0, still after 64 cycles.
- Backpressure and input isolation:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and product stable.
  - Toggle in_valid, a and b during RUN -> in_ready=0, and the result is unaffected (a=12, b=10 -> 120).
- Flush mid-operation: assert flush for one cycle at RUN step 20 -> out_valid never rises, busy=0 and in_ready=1 next cycle. A following a=9, b=9 yields 81 after 64 cycles, showing no residue from the cancelled operation.
- Reset mid-RUN and in DONE: assert reset at step 30, and separately while waiting in DONE -> next cycle state is IDLE, product=0, out_valid=0. Also assert reset together with flush and in_valid -> reset wins and no operand is accepted.

Source files
------------

// File: rtl/iter_mult_ctrl.sv
// iter_mult_ctrl: multi-cycle shift-add multiplier sequencer and datapath
// backing the MUL instruction in the execute stage.
//
// One multiplier bit is consumed per clock. An accepted operation always
// takes exactly WIDTH steps, with no early exit for small operands. The low
// WIDTH bits of a*b are then presented until the consumer takes them. The
// low half of a two's-complement product matches the unsigned one, so the
// same result serves signed and unsigned MUL.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; beats flush and all handshakes
//   in_valid   a/b valid this cycle
//   in_ready   operands accepted (high only in IDLE)
//   a, b       multiplicand, multiplier
//   flush      cancel an in-flight or completed-but-unread operation
//   out_valid  product valid (high only in DONE)
//   out_ready  consumer takes the product this cycle
//   product    low WIDTH bits of a*b
//   busy       state is not IDLE (pipeline stall)
module iter_mult_ctrl #(
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_next;

  // Carry-out is dropped. Only the low WIDTH bits of the product are kept.
  assign acc_next = mplier[0] ? acc + mcand : acc;

  // The handshake outputs are flops. They are updated together with state,
  // so there is no path from any input to any output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            mcand    <= a;
            mplier   <= b;
            acc      <= '0;
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        RUN: begin
          if (flush) begin
            state    <= IDLE;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
            // The final step publishes its own sum, not the stale acc.
            if (count == LAST_STEP) begin
              product   <= acc_next;
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          // If flush arrives with out_ready, the transfer is a cancel.
          // Both cases leave through the same path.
          if (flush || out_ready) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          count     <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
